// File: rtl/modulo_sweep_seq_if.sv
// Operand/result bundle between the sweep sequencer, the modulo core and the downstream consumer.
// The master side is the sequencer; the slave side is whoever drives start, y_in and res_ready.
interface modulo_sweep_seq_if #(
  parameter int W     = 2,
  parameter int RES_W = 3,
  parameter int SUM_W = 8
);
  logic             start;
  logic [W-1:0]     a_out;
  logic [W-1:0]     b_out;
  logic [RES_W-1:0] y_in;
  logic             res_valid;
  logic             res_ready;
  logic [W-1:0]     res_a;
  logic [W-1:0]     res_b;
  logic [RES_W-1:0] res_y;
  logic             busy;
  logic             done;
  logic [SUM_W-1:0] checksum;

  modport master (
    input  start, y_in, res_ready,
    output a_out, b_out, res_valid, res_a, res_b, res_y, busy, done, checksum
  );

  modport slave (
    output start, y_in, res_ready,
    input  a_out, b_out, res_valid, res_a, res_b, res_y, busy, done, checksum
  );
endinterface

// File: rtl/modulo_sweep_seq.sv
// Exhaustive (a,b) operand sweeper for a combinational modulo core: drives each pair, samples y
// after HOLD cycles, hands the beat downstream over valid/ready and keeps a running checksum.
module modulo_sweep_seq #(
  parameter int W       = 2,
  parameter int RES_W   = 3,
  parameter int HOLD    = 1,
  parameter int SKIP_ZB = 0,
  parameter int SUM_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  modulo_sweep_seq_if.master  bus
);

  localparam logic [W-1:0] B_FIRST = (SKIP_ZB != 0) ? W'(1) : W'(0);
  localparam logic [W-1:0] OP_MAX  = {W{1'b1}};
  localparam logic [3:0]   HOLD_LD = 4'(HOLD);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_OUT   = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  state_t           state_r;
  logic [3:0]       hold_cnt_r;
  logic [W-1:0]     a_r;
  logic [W-1:0]     b_r;
  logic [W-1:0]     res_a_r;
  logic [W-1:0]     res_b_r;
  logic [RES_W-1:0] res_y_r;
  logic             res_valid_r;
  logic             busy_r;
  logic             done_r;
  logic [SUM_W-1:0] checksum_r;

  logic             last_pair_s;
  logic [W-1:0]     next_a_s;
  logic [W-1:0]     next_b_s;

  // Successor pair: b wraps to its first legal value, which also keeps skipped pairs out.
  always_comb begin
    last_pair_s = (a_r == OP_MAX) && (b_r == OP_MAX);
    if (b_r == OP_MAX) begin
      next_b_s = B_FIRST;
      next_a_s = a_r + W'(1);
    end else begin
      next_b_s = b_r + W'(1);
      next_a_s = a_r;
    end
  end

  // Sweep FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      hold_cnt_r  <= 4'd0;
      a_r         <= '0;
      b_r         <= '0;
      res_a_r     <= '0;
      res_b_r     <= '0;
      res_y_r     <= '0;
      res_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      checksum_r  <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            checksum_r <= '0;
            a_r        <= '0;
            b_r        <= B_FIRST;
            hold_cnt_r <= HOLD_LD;
            busy_r     <= 1'b1;
            state_r    <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          // Final count cycle: y_in has now been stable for HOLD cycles.
          if (hold_cnt_r <= 4'd1) begin
            hold_cnt_r  <= 4'd0;
            res_a_r     <= a_r;
            res_b_r     <= b_r;
            res_y_r     <= bus.y_in;
            res_valid_r <= 1'b1;
            state_r     <= ST_OUT;
          end else begin
            hold_cnt_r <= hold_cnt_r - 4'd1;
          end
        end
        ST_OUT: begin
          if (bus.res_ready) begin
            checksum_r  <= checksum_r + SUM_W'(res_y_r);
            res_valid_r <= 1'b0;
            if (last_pair_s) begin
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              state_r <= ST_FIN;
            end else begin
              a_r        <= next_a_s;
              b_r        <= next_b_s;
              hold_cnt_r <= HOLD_LD;
              state_r    <= ST_DRIVE;
            end
          end
        end
        ST_FIN: begin
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r     <= ST_IDLE;
          res_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.a_out     = a_r;
  assign bus.b_out     = b_r;
  assign bus.res_a     = res_a_r;
  assign bus.res_b     = res_b_r;
  assign bus.res_y     = res_y_r;
  assign bus.res_valid = res_valid_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.checksum  = checksum_r;

endmodule
